// File: rtl/normalize_stage.sv
// Two-stage floating-point normalizer: stage 1 finds the leading-zero count,
// stage 2 shifts left by min(LZ, exponent) and adjusts the exponent.
module normalize_stage #(
  parameter int WIDTH = 32,
  parameter int EXPW  = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InMant,
  input  logic [EXPW-1:0]  InExp,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutMant,
  output logic [EXPW-1:0]  OutExp,
  output logic             OutZero,
  output logic             OutUnderflow
);

  localparam int LW = $clog2(WIDTH);
  localparam int CW = (EXPW > LW) ? EXPW : LW;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_mant_q;
  logic [EXPW-1:0]  s1_exp_q;
  logic [LW-1:0]    s1_lz_q;
  logic             s1_zero_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_mant_q;
  logic [EXPW-1:0]  s2_exp_q;
  logic             s2_zero_q;
  logic             s2_uf_q;

  logic [LW-1:0]    lz_d;
  logic             zero_d;
  logic             s1_en;
  logic             s2_en;
  logic [CW-1:0]    lz_ext;
  logic [CW-1:0]    exp_ext;
  logic [CW-1:0]    sh;
  logic             clamp;
  logic [WIDTH-1:0] mant_d;
  logic [EXPW-1:0]  exp_d;
  logic             uf_d;

  // Highest set bit wins; an all-zero mantissa is flagged separately.
  always_comb begin
    lz_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (InMant[i]) lz_d = LW'(WIDTH - 1 - i);
    end
    zero_d = ~|InMant;
  end

  assign s2_en   = !s2_valid_q || OutReady;
  assign s1_en   = !s1_valid_q || s2_en;
  assign InReady = !Reset && s1_en;

  always_comb begin
    lz_ext  = CW'(s1_lz_q);
    exp_ext = CW'(s1_exp_q);
    clamp   = lz_ext > exp_ext;
    sh      = clamp ? exp_ext : lz_ext;
    mant_d  = s1_zero_q ? '0 : (s1_mant_q << sh);
    exp_d   = s1_zero_q ? '0 : (s1_exp_q - EXPW'(sh));
    uf_d    = !s1_zero_q && clamp;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_lz_q    <= '0;
      s1_zero_q  <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= InValid;
      if (InValid) begin
        s1_mant_q <= InMant;
        s1_exp_q  <= InExp;
        s1_lz_q   <= lz_d;
        s1_zero_q <= zero_d;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s2_valid_q <= 1'b0;
      s2_mant_q  <= '0;
      s2_exp_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_uf_q    <= 1'b0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mant_q <= mant_d;
        s2_exp_q  <= exp_d;
        s2_zero_q <= s1_zero_q;
        s2_uf_q   <= uf_d;
      end
    end
  end

  assign OutValid     = s2_valid_q;
  assign OutMant      = s2_mant_q;
  assign OutExp       = s2_exp_q;
  assign OutZero      = s2_zero_q;
  assign OutUnderflow = s2_uf_q;

endmodule

// File: tb/tb_normalize_stage.sv
// Bench for normalize_stage: directed literal cases plus a queue-based model
// checked every cycle on the falling clock edge.
module tb_normalize_stage;

  logic        Clock;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] InMant;
  logic [7:0]  InExp;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutMant;
  logic [7:0]  OutExp;
  logic        OutZero;
  logic        OutUnderflow;

  normalize_stage #(.WIDTH(32), .EXPW(8)) dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady), .InMant(InMant), .InExp(InExp),
    .OutValid(OutValid), .OutReady(OutReady), .OutMant(OutMant),
    .OutExp(OutExp), .OutZero(OutZero), .OutUnderflow(OutUnderflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] m;
    logic [7:0]  e;
    logic        z;
    logic        u;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_drain = 0;
  int   pops = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Leading zeros from the position of the top set bit: msb = clog2(m+1)-1.
  function automatic exp_t model(input logic [31:0] m, input logic [7:0] e);
    exp_t r;
    longint unsigned msb;
    int lz;
    int sh;
    r.acc = 0;
    if (m == 32'd0) begin
      r.m = '0; r.e = '0; r.z = 1'b1; r.u = 1'b0;
    end else begin
      msb = longint'($clog2({32'd0, m} + 64'd1)) - 1;
      lz  = 31 - int'(msb);
      sh  = (lz < int'(e)) ? lz : int'(e);
      r.m = m << sh;
      r.e = 8'(int'(e) - sh);
      r.z = 1'b0;
      r.u = lz > int'(e);
    end
    return r;
  endfunction

  // Compare process: model output validity, InReady and data every cycle.
  initial begin
    exp_t it;
    bit   exp_v;
    int   vis;
    forever begin
      @(negedge Clock);
      cyc++;
      if (Reset) begin
        chk(OutValid == 1'b0, "rst_outvalid", OutValid, 0);
        chk(InReady == 1'b0, "rst_inready", InReady, 0);
        chk({OutMant, OutExp, OutZero, OutUnderflow} == '0, "rst_outputs",
            {OutMant, OutExp, OutZero, OutUnderflow}, 0);
        q.delete();
        last_drain = cyc;
      end else begin
        exp_v = 1'b0;
        if (q.size() > 0) begin
          vis = q[0].acc + 2;
          if (last_drain + 1 > vis) vis = last_drain + 1;
          exp_v = (cyc >= vis);
        end
        chk(OutValid == exp_v, "outvalid", OutValid, exp_v);
        chk(InReady == ((q.size() < 2) || OutReady), "inready", InReady,
            (q.size() < 2) || OutReady);
        if (exp_v) begin
          chk(OutMant == q[0].m, "outmant", OutMant, q[0].m);
          chk(OutExp == q[0].e, "outexp", OutExp, q[0].e);
          chk({OutZero, OutUnderflow} == {q[0].z, q[0].u}, "zero_uf",
              {OutZero, OutUnderflow}, {q[0].z, q[0].u});
          if (OutReady) begin
            void'(q.pop_front());
            last_drain = cyc;
            pops++;
          end
        end
        if (InValid && InReady) begin
          it = model(InMant, InExp);
          it.acc = cyc;
          q.push_back(it);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic directed(input logic [31:0] m, input logic [7:0] e, input logic [31:0] em,
                          input logic [7:0] ee, input bit ez, input bit eu, input string nm);
    InValid = 1'b1; InMant = m; InExp = e; OutReady = 1'b1;
    step();
    InValid = 1'b0; InMant = '0; InExp = '0;
    step();
    chk(OutValid == 1'b1, {nm, "_valid"}, OutValid, 1);
    chk(OutMant == em, {nm, "_mant"}, OutMant, em);
    chk(OutExp == ee, {nm, "_exp"}, OutExp, ee);
    chk(OutZero == ez, {nm, "_zero"}, OutZero, ez);
    chk(OutUnderflow == eu, {nm, "_uf"}, OutUnderflow, eu);
    step();
  endtask

  task automatic drain(input string nm);
    int g;
    InValid = 1'b0;
    OutReady = 1'b1;
    g = 0;
    while (q.size() != 0 && g < 50) begin
      step();
      g++;
    end
    chk(q.size() == 0, nm, q.size(), 0);
  endtask

  initial begin
    int          t;
    int          idx;
    int          p0;
    bit          acc;
    logic [31:0] hold_m;
    int          n;
    int          sb;
    int          guard;
    bit          pending;

    Reset = 1'b1; InValid = 1'b0; InMant = '0; InExp = '0; OutReady = 1'b1;
    #2;
    chk(OutValid == 1'b0, "init_outvalid", OutValid, 0);
    chk(InReady == 1'b0, "init_inready", InReady, 0);
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    chk(InReady == 1'b1, "ready_after_reset", InReady, 1);

    directed(32'h0000_0001, 8'd100, 32'h8000_0000, 8'd69, 1'b0, 1'b0, "norm");
    directed(32'h0000_0F00, 8'd10,  32'h003C_0000, 8'd0,  1'b0, 1'b1, "uflow");
    directed(32'h0000_0000, 8'd55,  32'h0000_0000, 8'd0,  1'b1, 1'b0, "zero");
    directed(32'h8000_0000, 8'd5,   32'h8000_0000, 8'd5,  1'b0, 1'b0, "passthru");
    directed(32'h0000_0100, 8'd23,  32'h8000_0000, 8'd0,  1'b0, 1'b0, "exact_fit");
    directed(32'h0000_0001, 8'd0,   32'h0000_0001, 8'd0,  1'b0, 1'b1, "exp_zero");

    // Backpressure: 8 operands, OutReady low for cycles 3..5.
    p0 = pops; idx = 0; t = 0; hold_m = '0;
    while (idx < 8 && t < 100) begin
      OutReady = !(t >= 3 && t <= 5);
      InValid  = 1'b1;
      InMant   = 32'h1 << (idx * 3 + 1);
      InExp    = 8'(20 + idx);
      @(negedge Clock);
      acc = InReady;
      if (t == 3) begin
        chk(InReady == 1'b0, "bp_full_ready", InReady, 0);
        hold_m = OutMant;
      end
      if (t == 5) chk(OutMant == hold_m, "bp_stall_stable", OutMant, hold_m);
      step();
      if (acc) idx++;
      t++;
    end
    chk(idx == 8, "bp_accept_all", idx, 8);
    drain("bp_drain");
    chk(pops - p0 == 8, "bp_result_count", pops - p0, 8);

    // Reset with two operands in flight.
    InValid = 1'b1; InMant = 32'h0000_1234; InExp = 8'd40; OutReady = 1'b1;
    step();
    InMant = 32'h0000_0077; InExp = 8'd3;
    step();
    InValid = 1'b0;
    chk(OutValid == 1'b1, "pre_rst_valid", OutValid, 1);
    Reset = 1'b1;
    #1;
    chk(OutValid == 1'b0, "rst_imm_valid", OutValid, 0);
    chk(OutMant == 32'd0, "rst_imm_mant", OutMant, 0);
    chk(InReady == 1'b0, "rst_imm_ready", InReady, 0);
    repeat (2) step();
    Reset = 1'b0;
    #1;
    chk(InReady == 1'b1, "ready_after_rst2", InReady, 1);
    repeat (4) step();
    directed(32'h0000_00F0, 8'd30, 32'hF000_0000, 8'd6, 1'b0, 1'b0, "post_rst");

    // Randomized sweep with random OutReady; first 32 operands are single-bit.
    n = 0; sb = 0; guard = 0; pending = 1'b0;
    while (n < 10000 && guard < 60000) begin
      OutReady = ($urandom_range(0, 9) < 7);
      if (!pending && $urandom_range(0, 3) != 0) begin
        pending = 1'b1;
        if (sb < 32) begin
          InMant = 32'h1 << sb;
          InExp  = 8'($urandom_range(0, 40));
          sb++;
        end else begin
          InMant = $urandom >> $urandom_range(0, 32);
          InExp  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
        end
      end
      InValid = pending;
      @(negedge Clock);
      acc = pending && InReady;
      step();
      if (acc) begin
        pending = 1'b0;
        n++;
      end
      guard++;
    end
    chk(n >= 10000, "sweep_count", n, 10000);
    drain("sweep_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/normalize_stage.md
NORMALIZE_STAGE -- requirements
Module: normalize_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the mantissa width; it must be a power of 2 and at least 4.
REQ-002 The block SHALL have parameter EXPW, default 8, giving the exponent width.
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port InValid, input, 1 bit: upstream operand valid.
REQ-006 The block SHALL have port InReady, output, 1 bit: the block accepts an operand this cycle.
REQ-007 The block SHALL have port InMant, input, WIDTH bits: unnormalized mantissa from the adder datapath.
REQ-008 The block SHALL have port InExp, input, EXPW bits: unbiased-agnostic exponent associated with InMant.
REQ-009 The block SHALL have port OutValid, output, 1 bit: result valid.
REQ-010 The block SHALL have port OutReady, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port OutMant, output, WIDTH bits: normalized mantissa.
REQ-012 The block SHALL have port OutExp, output, EXPW bits: adjusted exponent.
REQ-013 The block SHALL have port OutZero, output, 1 bit: the input mantissa was zero.
REQ-014 The block SHALL have port OutUnderflow, output, 1 bit: the shift was clamped by the exponent.

Function
REQ-015 Transfers SHALL occur on an input only when InValid and InReady are both 1 on a rising edge, and on an output only when OutValid and OutReady are both 1.
REQ-016 The block SHALL be a 2-stage pipeline:
- Stage 1 registers InMant, InExp and a leading-zero count LZ (width $clog2(WIDTH)), plus a zero flag.
- Stage 2 registers the shifted result.
REQ-017 Latency SHALL be exactly 2 cycles from input acceptance to OutValid=1 when OutReady is held 1; throughput SHALL be 1 result per cycle.
REQ-018 Effective shift SH SHALL be min(LZ, InExp), compared as unsigned.
- OutMant = mantissa shifted left by SH, with zeros filled in from the LSB (shift-in 0).
- OutExp = InExp - SH; this never wraps below 0.
REQ-019 OutUnderflow SHALL be 1 if and only if LZ > InExp and the mantissa is nonzero.
REQ-020 For InMant = 0, the result SHALL be OutMant = 0, OutExp = 0, OutZero = 1 and OutUnderflow = 0.
REQ-021 For InMant[WIDTH-1] = 1, SH SHALL be 0 and the mantissa and exponent SHALL pass unchanged.
REQ-022 Each stage register SHALL load when it is empty or when its contents advance in the same cycle; otherwise it SHALL hold.
REQ-023 InReady SHALL equal (!S1Valid) OR (stage 2 is empty or being drained in this cycle); InReady is combinational from OutReady.
REQ-024 While OutValid = 1 and OutReady = 0, OutMant, OutExp, OutZero and OutUnderflow SHALL remain stable.
REQ-025 No operand SHALL be dropped or duplicated under any pattern of InValid and OutReady.
REQ-026 Simultaneous accept and drain SHALL occur in the same cycle without a bubble.

Reset
REQ-027 Assertion of Reset SHALL immediately clear both stage-valid bits and all output registers: OutValid = 0, OutMant = 0, OutExp = 0, OutZero = 0, OutUnderflow = 0.
REQ-028 Reset asserted mid-stream SHALL discard in-flight operands; no result from before reset SHALL appear after deassertion.
REQ-029 While Reset = 1, InReady SHALL be 0.
REQ-030 InReady SHALL be 1 on the first cycle after Reset deassertion.

Verification (WIDTH = 32, EXPW = 8, OutReady = 1 unless stated)
REQ-031 Bench SHALL cover normal normalization: InMant = 0x0000_0001, InExp = 100 -> 2 cycles later OutMant = 0x8000_0000, OutExp = 69, OutUnderflow = 0.
REQ-032 Bench SHALL cover clamped underflow: InMant = 0x0000_0F00, InExp = 10 -> OutMant = 0x003C_0000, OutExp = 0, OutUnderflow = 1.
REQ-033 Bench SHALL cover the zero and already-normalized cases:
- InMant = 0, InExp = 55 -> OutMant = 0, OutExp = 0, OutZero = 1.
- InMant = 0x8000_0000, InExp = 5 -> output unchanged.
REQ-034 Bench SHALL cover backpressure: stream 8 operands back-to-back with OutReady = 0 for 3 cycles mid-stream -> all 8 results appear in order, each exactly once, outputs stable during the stall, InReady = 0 once both stages are full.
REQ-035 Bench SHALL cover reset mid-operation: assert Reset with 2 operands in flight -> OutValid = 0 immediately; after deassertion, no stale result appears and a new operand produces its result after 2 cycles.
REQ-036 Bench SHALL run a randomized sweep of at least 10,000 operands, including all single-bit mantissas, with random OutReady against a reference model computing min(LZ, InExp); zero mismatches are required.
